reg_file: RTL and testbench

- rv32i integer register file: 32 x 32-bit registers, two combinational read ports, one synchronous write port.
- Sits directly upstream of the ALU in the single-cycle datapath.
- Read port 1 drives ALU in_a. Read port 2 drives ALU in_b, or the store-data path when the immediate mux selects imm.
- The writeback path (ALU result / load data) returns to the write port.
- x0 is hardwired to zero.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/reg_file.sv | 48 ++++
 tb/tb_reg_file.sv | 131 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared rv32i datapath definitions: widths, common word/address types, ALU op encodings.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
endpackage

// File: rtl/reg_file.sv
// rv32i integer register file: two combinational read ports, one synchronous write port,
// x0 hardwired to zero, optional same-cycle write-through bypass.
module reg_file #(
  parameter int XLEN          = riscv_pkg::XLEN,
  parameter int NUM_REGS      = riscv_pkg::NUM_REGS,
  parameter bit WRITE_THROUGH = 1'b0,
  localparam int AW           = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rd_addr_1,
  input  logic [AW-1:0]   rd_addr_2,
  output logic [XLEN-1:0] rd_data_1,
  output logic [XLEN-1:0] rd_data_2,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);
  import riscv_pkg::*;

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic            wr_fire;

  // Entry 0 is cleared on reset and never written, so it stays zero.
  assign wr_fire = wr_en && (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_fire) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Bypass only when the write will actually land on this edge (not under reset).
  function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = regs_q[addr];
    if (WRITE_THROUGH && rst_n && wr_fire && (wr_addr == addr)) val = wr_data;
    if (addr == '0) val = '0;
    return val;
  endfunction

  always_comb begin
    rd_data_1 = rd_port(rd_addr_1);
    rd_data_2 = rd_port(rd_addr_2);
  end
endmodule

// File: tb/tb_reg_file.sv
// Directed + model-checked bench for reg_file; runs a write-through=0 and =1 instance side by side.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr_1, rd_addr_2, wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] r1_0, r2_0, r1_1, r2_1;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] mdl [32];

  always #5 clk = ~clk;

  reg_file #(.WRITE_THROUGH(1'b0)) u_wt0 (
    .clk(clk), .rst_n(rst_n), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(r1_0), .rd_data_2(r2_0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  reg_file #(.WRITE_THROUGH(1'b1)) u_wt1 (
    .clk(clk), .rst_n(rst_n), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(r1_1), .rd_data_2(r2_1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always @(posedge clk) if (rst_n === 1'b1) assert (!$isunknown(wr_en));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_1 = '0; rd_addr_2 = '0;
    #1;
    // 1: pre-fill with ones, reset, every address reads zero on both ports
    for (int i = 1; i < 32; i++) wr(5'(i), 32'hFFFF_FFFF);
    rd_addr_1 = 5'd17; #1;
    chk("prefill", r1_0, 32'hFFFF_FFFF);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_addr_1 = 5'(i); rd_addr_2 = 5'(31 - i); #1;
      chk("rst_p1_wt0", r1_0, 32'h0); chk("rst_p2_wt0", r2_0, 32'h0);
      chk("rst_p1_wt1", r1_1, 32'h0); chk("rst_p2_wt1", r2_1, 32'h0);
    end

    // 2: basic writes, other registers untouched
    wr(5'd5, 32'hDEAD_BEEF);
    wr(5'd31, 32'h0000_0001);
    rd_addr_1 = 5'd5; rd_addr_2 = 5'd31; #1;
    chk("x5_p1", r1_0, 32'hDEAD_BEEF); chk("x31_p2", r2_0, 32'h0000_0001);
    chk("x5_p1_wt1", r1_1, 32'hDEAD_BEEF);
    rd_addr_1 = 5'd4; rd_addr_2 = 5'd6; #1;
    chk("x4_zero", r1_0, 32'h0); chk("x6_zero", r2_0, 32'h0);
    rd_addr_1 = 5'd5; rd_addr_2 = 5'd5; #1;
    chk("same_addr", r2_0, 32'hDEAD_BEEF);

    // 3: writes to x0 are dropped, reads of x0 are zero even with bypass
    rd_addr_1 = 5'd0; rd_addr_2 = 5'd0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678; #1;
    chk("x0_same_wt0", r1_0, 32'h0); chk("x0_same_wt1", r1_1, 32'h0);
    chk("x0_same_wt1_p2", r2_1, 32'h0);
    tick(); wr_en = 1'b0; #1;
    chk("x0_next_wt0", r1_0, 32'h0); chk("x0_next_wt1", r2_1, 32'h0);

    // 4: same-cycle read/write collision
    wr(5'd7, 32'hAAAA_AAAA);
    rd_addr_1 = 5'd7; rd_addr_2 = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h5555_5555; #1;
    chk("coll_wt0", r1_0, 32'hAAAA_AAAA); chk("coll_wt1", r1_1, 32'h5555_5555);
    chk("coll_wt1_p2", r2_1, 32'h5555_5555);
    tick(); wr_en = 1'b0; #1;
    chk("coll_next_wt0", r1_0, 32'h5555_5555); chk("coll_next_wt1", r1_1, 32'h5555_5555);

    // rst_n low between edges has no effect
    rst_n = 1'b0; #2;
    chk("async_rst_none", r1_0, 32'h5555_5555);
    rst_n = 1'b1;

    // X on address/data with wr_en low must not corrupt state
    wr_addr = 'x; wr_data = 'x; tick();
    rd_addr_2 = 5'd31; #1;
    chk("x_idle_x7", r1_0, 32'h5555_5555); chk("x_idle_x31", r2_0, 32'h0000_0001);
    wr_addr = '0; wr_data = '0;

    // 5: reset beats a same-cycle write; bypass suppressed during reset
    rd_addr_1 = 5'd3; rd_addr_2 = 5'd7;
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE_F00D; #1;
    chk("rst_byp_wt1", r1_1, 32'h0); chk("rst_byp_wt0", r1_0, 32'h0);
    tick(); rst_n = 1'b1; wr_en = 1'b0; #1;
    chk("rst_wr_x3_wt0", r1_0, 32'h0); chk("rst_wr_x3_wt1", r1_1, 32'h0);
    chk("rst_mid_x7", r2_0, 32'h0);

    // 6: randomized traffic against a reference array
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int c = 0; c < 2000; c++) begin
      logic [31:0] e1, e2;
      rd_addr_1 = 5'($urandom_range(0, 31));
      rd_addr_2 = 5'($urandom_range(0, 31));
      wr_en     = ($urandom_range(0, 3) != 0);
      wr_addr   = ($urandom_range(0, 3) == 0) ? rd_addr_1 : 5'($urandom_range(0, 31));
      wr_data   = $urandom;
      rst_n     = ($urandom_range(0, 63) != 0);
      #1;
      e1 = (rd_addr_1 == 0) ? 32'h0 : mdl[rd_addr_1];
      e2 = (rd_addr_2 == 0) ? 32'h0 : mdl[rd_addr_2];
      chk("rnd_p1_wt0", r1_0, e1); chk("rnd_p2_wt0", r2_0, e2);
      if (rst_n && wr_en && wr_addr != 0 && wr_addr == rd_addr_1) e1 = wr_data;
      if (rst_n && wr_en && wr_addr != 0 && wr_addr == rd_addr_2) e2 = wr_data;
      chk("rnd_p1_wt1", r1_1, e1); chk("rnd_p2_wt1", r2_1, e2);
      tick();
      if (!rst_n) for (int i = 0; i < 32; i++) mdl[i] = '0;
      else if (wr_en && wr_addr != 0) mdl[wr_addr] = wr_data;
    end
    rst_n = 1'b1; wr_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
